// File: rtl/fetch_queue_ctrl_pkg.sv
// Shared definitions for the fetch queue controller slice.
// Provides the queue and fetch sizing constants, the controller state type,
// derived counter widths and a 2-bit popcount helper.
package fetch_queue_ctrl_pkg;

    localparam int unsigned FQ_DEPTH           = 32;
    // Headroom of 3 entries keeps the FIFO's conservative full/stall flags quiet.
    localparam int unsigned FQ_LIMIT           = FQ_DEPTH - 3;
    localparam int unsigned FETCH_MAX_INFLIGHT = 4;
    localparam int unsigned FETCH_BYTES        = 8;
    localparam logic [31:0] RESET_PC           = 32'h1c00_0000;

    localparam int unsigned FQ_OCC_W  = $clog2(FQ_DEPTH) + 1;
    localparam int unsigned FQ_INFL_W = $clog2(FETCH_MAX_INFLIGHT) + 1;

    typedef enum logic {
        FQ_RUN   = 1'b0,
        FQ_DRAIN = 1'b1
    } fq_state_e;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/fetch_queue_ctrl_occ_counter.sv
// Exact occupancy tracker for the dual-port instruction queue.
// Ports:
//   clk, rst  - clock, synchronous active-low reset
//   clr_i     - synchronous clear (flush)
//   enq_i     - FIFO enqueue enables; each set bit adds one entry
//   deq_i     - entries popped this cycle (0..2)
//   occ_o     - current entry count
module fq_occ_counter
    import fetch_queue_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH,
    parameter int unsigned LIMIT = DEPTH - 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic [1:0]               enq_i,
    input  logic [1:0]               deq_i,
    output logic [$clog2(DEPTH):0]   occ_o
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // No saturation: the credit scheme upstream guarantees the count stays in range.
    always_comb begin
        occ_d = occ_q + OCC_W'(popcount2(enq_i)) - OCC_W'(deq_i);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q <= '0;
        end else if (clr_i) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
            assert (OCC_W'(deq_i) <= occ_q);
            assert (occ_d <= OCC_W'(LIMIT));
        end
    end

    assign occ_o = occ_q;

endmodule

// File: rtl/fetch_queue_ctrl.sv
// Fetch sequencing controller in front of the decode instruction queue.
// Issues fetch requests only when the queue has room for every in-flight
// response, turns responses into FIFO enqueue enables, tracks occupancy and
// outstanding requests, and drains stale responses after a redirect.
// Ports:
//   clk, rst                        - clock, synchronous active-low reset
//   flush, flush_pc                 - redirect pulse and its 8-byte aligned target
//   fetch_req_valid/ready/pc        - request handshake to the front end
//   fetch_resp_valid, fetch_resp_mask - in-order response with slot mask
//   enqueue_en                      - FIFO enqueue enables (zero-latency)
//   deq_cnt                         - entries popped by the decoder
//   occupancy, inflight, draining   - status
module fetch_queue_ctrl
    import fetch_queue_ctrl_pkg::*;
#(
    parameter int unsigned       DEPTH        = FQ_DEPTH,
    parameter int unsigned       MAX_INFLIGHT = FETCH_MAX_INFLIGHT,
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC     = ADDR_W'(fetch_queue_ctrl_pkg::RESET_PC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [ADDR_W-1:0]             flush_pc,
    output logic                          fetch_req_valid,
    input  logic                          fetch_req_ready,
    output logic [ADDR_W-1:0]             fetch_req_pc,
    input  logic                          fetch_resp_valid,
    input  logic [1:0]                    fetch_resp_mask,
    output logic [1:0]                    enqueue_en,
    input  logic [1:0]                    deq_cnt,
    output logic [$clog2(DEPTH):0]        occupancy,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          draining
);

    localparam int unsigned OCC_W  = $clog2(DEPTH) + 1;
    localparam int unsigned INFL_W = $clog2(MAX_INFLIGHT) + 1;
    localparam int          LIMIT  = int'(DEPTH) - 3;

    fq_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INFL_W-1:0] infl_q, infl_d;
    logic [OCC_W-1:0]  occ;
    logic              run;
    logic              req_v;
    logic              hs;
    logic [1:0]        enq;
    logic [1:0]        deq_eff;
    int                credit;

    // Normal-operation qualifier shared by request issue and enqueue.
    assign run = (state_q == FQ_RUN) && !flush && rst;

    always_comb begin
        // Each in-flight request may still deliver two entries.
        credit  = LIMIT - int'(occ) - 2 * int'(infl_q);
        req_v   = run && (infl_q < INFL_W'(MAX_INFLIGHT)) && (credit >= 2);
        hs      = req_v && fetch_req_ready;
        enq     = (fetch_resp_valid && run) ? fetch_resp_mask : 2'b00;
        deq_eff = run ? deq_cnt : 2'b00;
        infl_d  = infl_q + INFL_W'(hs) - INFL_W'(fetch_resp_valid);
        pc_d    = hs ? pc_q + ADDR_W'(FETCH_BYTES) : pc_q;
        state_d = state_q;
        if (flush) begin
            pc_d    = flush_pc;
            state_d = (infl_d != '0) ? FQ_DRAIN : FQ_RUN;
        end else if (state_q == FQ_DRAIN && infl_d == '0) begin
            state_d = FQ_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FQ_RUN;
            pc_q    <= RESET_PC;
            infl_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            infl_q  <= infl_d;
            if (fetch_resp_valid) begin
                assert (infl_q != '0);
            end
        end
    end

    fq_occ_counter #(
        .DEPTH (DEPTH),
        .LIMIT (DEPTH - 3)
    ) u_occ (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .enq_i (enq),
        .deq_i (deq_eff),
        .occ_o (occ)
    );

    assign fetch_req_valid = req_v;
    assign fetch_req_pc    = pc_q;
    assign enqueue_en      = enq;
    assign occupancy       = occ;
    assign inflight        = infl_q;
    assign draining        = (state_q == FQ_DRAIN);

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
module tb_fetch_queue_ctrl;

    localparam int          LIM  = 29;
    localparam logic [31:0] RPC  = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_req_valid;
    logic        fetch_req_ready;
    logic [31:0] fetch_req_pc;
    logic        fetch_resp_valid;
    logic [1:0]  fetch_resp_mask;
    logic [1:0]  enqueue_en;
    logic [1:0]  deq_cnt;
    logic [5:0]  occupancy;
    logic [2:0]  inflight;
    logic        draining;

    int          errors = 0;
    int          checks = 0;

    // reference model state
    bit          m_drain = 1'b0;
    logic [31:0] m_pc = RPC;
    int          m_occ = 0;
    int          m_infl = 0;
    bit          chk_state = 1'b0;
    bit          auto_resp = 1'b0;
    int          pend = 0;
    logic [1:0]  enq_q[$];

    always #5 clk = ~clk;

    fetch_queue_ctrl #(
        .DEPTH        (32),
        .MAX_INFLIGHT (4),
        .ADDR_W       (32),
        .RESET_PC     (32'h1c00_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .fetch_req_valid  (fetch_req_valid),
        .fetch_req_ready  (fetch_req_ready),
        .fetch_req_pc     (fetch_req_pc),
        .fetch_resp_valid (fetch_resp_valid),
        .fetch_resp_mask  (fetch_resp_mask),
        .enqueue_en       (enqueue_en),
        .deq_cnt          (deq_cnt),
        .occupancy        (occupancy),
        .inflight         (inflight),
        .draining         (draining)
    );

    // Apply inputs at the falling edge; push the expected enqueue result.
    task automatic drive(input bit r, input bit fl, input logic [31:0] fpc,
                         input bit rv, input logic [1:0] mk, input logic [1:0] dq,
                         input bit rdy);
        rst              = r;
        flush            = fl;
        flush_pc         = fpc;
        fetch_resp_valid = rv;
        fetch_resp_mask  = mk;
        deq_cnt          = dq;
        fetch_req_ready  = rdy;
        if (rv)
            enq_q.push_back((r && !fl && !m_drain) ? mk : 2'b00);
    endtask

    // Check outputs mid-cycle, advance the model, then move to the next falling edge.
    task automatic step();
        bit         ev;
        bit         hs;
        logic [1:0] eq;
        #1;
        ev = rst && !flush && !m_drain && (m_infl < 4) && ((LIM - m_occ - 2 * m_infl) >= 2);
        checks++;
        if (fetch_req_valid !== ev) begin
            errors++;
            $display("FAIL req_valid t=%0t got=%b exp=%b", $time, fetch_req_valid, ev);
        end
        if (ev) begin
            checks++;
            if (fetch_req_pc !== m_pc) begin
                errors++;
                $display("FAIL req_pc t=%0t got=%h exp=%h", $time, fetch_req_pc, m_pc);
            end
        end
        if (fetch_resp_valid) begin
            checks++;
            if (enq_q.size() == 0) begin
                errors++;
                $display("FAIL enq_scoreboard_empty t=%0t got=%b exp=none", $time, enqueue_en);
            end else begin
                eq = enq_q.pop_front();
                if (enqueue_en !== eq) begin
                    errors++;
                    $display("FAIL enqueue_en t=%0t got=%b exp=%b", $time, enqueue_en, eq);
                end
            end
        end else begin
            checks++;
            if (enqueue_en !== 2'b00) begin
                errors++;
                $display("FAIL enqueue_idle t=%0t got=%b exp=00", $time, enqueue_en);
            end
        end
        if (chk_state) begin
            checks++;
            if (occupancy !== 6'(m_occ)) begin
                errors++;
                $display("FAIL occupancy t=%0t got=%0d exp=%0d", $time, occupancy, m_occ);
            end
            checks++;
            if (inflight !== 3'(m_infl)) begin
                errors++;
                $display("FAIL inflight t=%0t got=%0d exp=%0d", $time, inflight, m_infl);
            end
            checks++;
            if (draining !== m_drain) begin
                errors++;
                $display("FAIL draining t=%0t got=%b exp=%b", $time, draining, m_drain);
            end
        end
        hs = ev && fetch_req_ready;
        if (!rst) begin
            m_drain = 1'b0;
            m_pc    = RPC;
            m_occ   = 0;
            m_infl  = 0;
        end else if (flush) begin
            m_occ   = 0;
            m_pc    = flush_pc;
            m_infl  = m_infl - int'(fetch_resp_valid);
            m_drain = (m_infl != 0);
        end else begin
            if (!m_drain) begin
                if (fetch_resp_valid)
                    m_occ = m_occ + int'(fetch_resp_mask[0]) + int'(fetch_resp_mask[1]);
                m_occ = m_occ - int'(deq_cnt);
            end
            m_infl = m_infl + int'(hs) - int'(fetch_resp_valid);
            if (hs)
                m_pc = m_pc + 32'd8;
            if (m_drain && m_infl == 0)
                m_drain = 1'b0;
        end
        if (auto_resp && hs)
            pend++;
        chk_state = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One cycle of the auto-responder: each accepted request answers a cycle later.
    task automatic auto_cycle(input logic [1:0] dq);
        bit rv;
        rv = (pend > 0);
        if (rv)
            pend--;
        drive(1'b1, 1'b0, 32'h0, rv, 2'b11, dq, 1'b1);
        step();
    endtask

    task automatic test_reset();
        chk_state = 1'b0;
        drive(1'b0, 1'b1, 32'h1234_5678, 1'b1, 2'b11, 2'b00, 1'b1);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b1);
        step();
        checks++;
        if (occupancy !== 6'd0) begin
            errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy);
        end
        checks++;
        if (inflight !== 3'd0) begin
            errors++; $display("FAIL reset_inflight got=%0d exp=0", inflight);
        end
        checks++;
        if (draining !== 1'b0) begin
            errors++; $display("FAIL reset_draining got=%b exp=0", draining);
        end
        checks++;
        if (fetch_req_pc !== 32'h1c00_0000) begin
            errors++; $display("FAIL reset_pc got=%h exp=1c000000", fetch_req_pc);
        end
    endtask

    task automatic test_fill();
        auto_resp = 1'b1;
        pend      = 0;
        checks++;
        if (fetch_req_pc !== 32'h1c00_0000) begin
            errors++; $display("FAIL fill_first_pc got=%h exp=1c000000", fetch_req_pc);
        end
        auto_cycle(2'b00);
        checks++;
        if (fetch_req_pc !== 32'h1c00_0008) begin
            errors++; $display("FAIL fill_second_pc got=%h exp=1c000008", fetch_req_pc);
        end
        for (int i = 0; i < 40; i++)
            auto_cycle(2'b00);
        checks++;
        if (occupancy !== 6'd28) begin
            errors++; $display("FAIL fill_occ_sat got=%0d exp=28", occupancy);
        end
        checks++;
        if (inflight !== 3'd0) begin
            errors++; $display("FAIL fill_inflight got=%0d exp=0", inflight);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b1);
        #1;
        checks++;
        if (fetch_req_valid !== 1'b0) begin
            errors++; $display("FAIL fill_valid_low got=%b exp=0", fetch_req_valid);
        end
        step();
    endtask

    task automatic test_credit();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b10, 1'b1);
        step();
        checks++;
        if (occupancy !== 6'd26) begin
            errors++; $display("FAIL credit_occ got=%0d exp=26", occupancy);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b1);
        #1;
        checks++;
        if (fetch_req_valid !== 1'b1) begin
            errors++; $display("FAIL credit_valid got=%b exp=1", fetch_req_valid);
        end
        step();
        auto_cycle(2'b00);
        auto_resp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, (m_occ >= 2) ? 2'b10 : 2'(m_occ), 1'b0);
            step();
        end
        checks++;
        if (occupancy !== 6'd0) begin
            errors++; $display("FAIL credit_drain_occ got=%0d exp=0", occupancy);
        end
    endtask

    task automatic test_inflight_cap();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b1);
            step();
        end
        checks++;
        if (inflight !== 3'd4) begin
            errors++; $display("FAIL cap_inflight got=%0d exp=4", inflight);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b1);
        #1;
        checks++;
        if (fetch_req_valid !== 1'b0) begin
            errors++; $display("FAIL cap_valid got=%b exp=0", fetch_req_valid);
        end
        step();
    endtask

    task automatic test_flush_drain();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 2'b11, 2'b00, 1'b0);
        step();
        drive(1'b1, 1'b1, 32'h1c00_1000, 1'b0, 2'b00, 2'b00, 1'b0);
        step();
        checks++;
        if (draining !== 1'b1) begin
            errors++; $display("FAIL flush_draining got=%b exp=1", draining);
        end
        checks++;
        if (occupancy !== 6'd0) begin
            errors++; $display("FAIL flush_occ got=%0d exp=0", occupancy);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1, 2'b11, 2'b01, 1'b1);
            step();
        end
        checks++;
        if (draining !== 1'b0) begin
            errors++; $display("FAIL drain_exit got=%b exp=0", draining);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b1);
        #1;
        checks++;
        if (fetch_req_valid !== 1'b1 || fetch_req_pc !== 32'h1c00_1000) begin
            errors++;
            $display("FAIL drain_resume got=%b/%h exp=1/1c001000", fetch_req_valid, fetch_req_pc);
        end
        step();
    endtask

    task automatic test_flush_resp();
        drive(1'b1, 1'b1, 32'h1c00_2000, 1'b1, 2'b11, 2'b00, 1'b1);
        step();
        checks++;
        if (inflight !== 3'd0 || draining !== 1'b0) begin
            errors++;
            $display("FAIL flush_resp_state got=%0d/%b exp=0/0", inflight, draining);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b1);
        #1;
        checks++;
        if (fetch_req_valid !== 1'b1 || fetch_req_pc !== 32'h1c00_2000) begin
            errors++;
            $display("FAIL flush_resp_resume got=%b/%h exp=1/1c002000", fetch_req_valid, fetch_req_pc);
        end
        step();
    endtask

    task automatic test_mask_deq();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 2'b11, 2'b00, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b1);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 2'b01, 1'b0);
        #1;
        checks++;
        if (enqueue_en !== 2'b10) begin
            errors++; $display("FAIL mask_enq got=%b exp=10", enqueue_en);
        end
        step();
        checks++;
        if (occupancy !== 6'd2) begin
            errors++; $display("FAIL mask_occ got=%0d exp=2", occupancy);
        end
    endtask

    task automatic test_reset_in_drain();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b1);
            step();
        end
        drive(1'b1, 1'b1, 32'h1c00_3000, 1'b0, 2'b00, 2'b00, 1'b0);
        step();
        drive(1'b1, 1'b1, 32'h1c00_4000, 1'b1, 2'b11, 2'b00, 1'b0);
        step();
        checks++;
        if (draining !== 1'b1 || inflight !== 3'd1) begin
            errors++;
            $display("FAIL drain_reflush got=%b/%0d exp=1/1", draining, inflight);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0);
        step();
        checks++;
        if (draining !== 1'b0 || inflight !== 3'd0 || fetch_req_pc !== 32'h1c00_0000) begin
            errors++;
            $display("FAIL drain_reset got=%b/%0d/%h exp=0/0/1c000000", draining, inflight, fetch_req_pc);
        end
    endtask

    task automatic test_pc_wrap();
        drive(1'b1, 1'b1, 32'hffff_fff8, 1'b0, 2'b00, 2'b00, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b1);
        step();
        checks++;
        if (fetch_req_pc !== 32'h0000_0000) begin
            errors++; $display("FAIL pc_wrap got=%h exp=00000000", fetch_req_pc);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b01, 1'b0);
        step();
        checks++;
        if (occupancy !== 6'd0) begin
            errors++; $display("FAIL wrap_occ got=%0d exp=0", occupancy);
        end
    endtask

    initial begin
        rst              = 1'b0;
        flush            = 1'b0;
        flush_pc         = '0;
        fetch_req_ready  = 1'b0;
        fetch_resp_valid = 1'b0;
        fetch_resp_mask  = '0;
        deq_cnt          = '0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_credit();
        test_inflight_cap();
        test_flush_drain();
        test_flush_resp();
        test_mask_deq();
        test_reset_in_drain();
        test_pc_wrap();
        checks++;
        if (enq_q.size() != 0) begin
            errors++; $display("FAIL enq_scoreboard_leftover got=%0d exp=0", enq_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
